mul_result_stage: RTL
=====================

# mul_result_stage

Registered result stage directly downstream of the 64-bit signed multiplier. It accepts the 128-bit product together with an operation code and a destination-register tag, then formats the product into a 64-bit writeback value (low, high, word or saturated). Formatted results are buffered in a 2-entry FIFO with a valid/ready handshake on both sides, which decouples the combinational multiplier from writeback back-pressure.

## Interface

- TAG_W, 5: width of the destination-register tag carried alongside each result.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  product, op and tag are valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_product  input  128  signed product from the multiplier.
- in_op  input  2  format select: 00 MUL, 01 MULH, 10 MULW, 11 MULSAT.
- in_rd  input  TAG_W  destination tag, passed through unchanged.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_result  output  64  formatted result.
- out_rd  output  TAG_W  tag of the head entry.
- out_ovf  output  1  product does not fit in signed 64 bits.
- out_zero  output  1  out_result == 0.

## Operation

- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Formatting is done at push time. Each FIFO entry stores {result[63:0], rd, ovf, zero}.
- ovf = NOT (in_product[127:63] all-zeros OR all-ones). ovf is computed for every op, not only MULSAT.
- Op 00 MUL: result = in_product[63:0].
- Op 01 MULH: result = in_product[127:64].
- Op 10 MULW: result = sign-extend in_product[31:0] to 64 bits.
- Op 11 MULSAT:
  - If ovf = 0: result = in_product[63:0].
  - If ovf = 1 and in_product[127] = 0: result = 0x7FFF_FFFF_FFFF_FFFF.
  - If ovf = 1 and in_product[127] = 1: result = 0x8000_0000_0000_0000.
- zero is evaluated on the formatted result.
- Storage: 2 entries, a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2). Both pointers wrap 1 -> 0.
- Count transitions:
  - 0 -> 1 on push.
  - 1 -> 2 on push without pop.
  - 1 -> 0 on pop without push.
  - 1 -> 1 on simultaneous push and pop.
  - 2 -> 1 on pop.
- Push at count 2 is impossible because in_ready = 0.
- Pop at count 0 is impossible because out_valid = 0.
- FIFO order is strict. No entry is dropped or duplicated.
- in_ready = (count != 2) and not in reset. It does not depend combinationally on out_ready, so a slot freed by a pop is visible one cycle later.
- out_valid = (count != 0).
- When out_valid = 0, out_result, out_rd, out_ovf and out_zero are driven to 0.
- Inputs are ignored while in_valid = 0 or in_ready = 0. in_product may change freely when no push occurs.

## Timing

- Reset asserted (asynchronous):
  - count, both pointers and all entries clear immediately.
  - out_valid = 0, all output data = 0, in_ready = 0.
- First rising edge after reset deasserts: in_ready = 1.
- Reset during operation discards all buffered entries, with no partial pop.
- Latency: an entry pushed at edge N appears at out_* after edge N when the FIFO was empty (1 cycle).
- Throughput: 1 result/cycle sustained while out_ready = 1.
- Back-pressure with out_ready held 0 from empty: accepts exactly 2 entries. in_ready goes low after the second push edge.
- At count 2, a pop at edge N raises in_ready after edge N. The next push can occur at edge N+1.
- out_* are stable while out_valid = 1 and out_ready = 0.

## Test plan

- Reset behaviour: assert reset mid-stream with 2 entries held -> out_valid = 0, out_result = 0 and in_ready = 0 immediately. After release, in_ready = 1 and count = 0.
- Formatting of 3 × -4 (product = -12, sign-extended to 128 bits):
  - op 00 -> out_result = 0xFFFF_FFFF_FFFF_FFF4, ovf = 0.
  - op 01 -> 0xFFFF_FFFF_FFFF_FFFF.
  - op 10 -> 0xFFFF_FFFF_FFFF_FFF4.
  - op 11 -> 0xFFFF_FFFF_FFFF_FFF4.
- Overflow of 2^64 (product[64] = 1, all other bits 0):
  - op 00 -> out_result = 0, ovf = 1, zero = 1.
  - op 01 -> out_result = 1.
  - op 11 -> 0x7FFF_FFFF_FFFF_FFFF.
  - For product = -2^64, op 11 -> 0x8000_0000_0000_0000.
- MULW of product = 0x8000_0000 -> out_result = 0xFFFF_FFFF_8000_0000, ovf = 0.
- Back-pressure: with out_ready = 0, offer tags 1, 2, 3 -> tags 1 and 2 accepted, in_ready = 0, tag 3 held. Raise out_ready -> tags 1, 2, 3 emerge in order with no loss.
- Streaming: in_valid = 1 and out_ready = 1 for 10 cycles with count = 1 -> one result per cycle, count stays 1 on simultaneous push/pop, pointers wrap correctly.

Source files
------------

// File: rtl/mul_result_stage.sv
// mul_result_stage: formats the 128-bit signed multiplier product into a
// 64-bit writeback value and buffers it in a 2-entry valid/ready FIFO.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake (push when both high)
//   in_product            128-bit signed product
//   in_op                 00 MUL, 01 MULH, 10 MULW, 11 MULSAT
//   in_rd                 destination tag, passed through
//   out_valid/out_ready   downstream handshake (pop when both high)
//   out_result            formatted 64-bit result of the head entry
//   out_rd                tag of the head entry
//   out_ovf               product does not fit in signed 64 bits
//   out_zero              out_result == 0
// All outputs are registered; out_* read zero while out_valid is low.
module mul_result_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_product,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 2;
    localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // Storage and pointers
    logic [1:0][DATA_W-1:0] mem_result, mem_result_n;
    logic [1:0][TAG_W-1:0]  mem_rd, mem_rd_n;
    logic [1:0]             mem_ovf, mem_ovf_n;
    logic [1:0]             mem_zero, mem_zero_n;
    logic                   wptr, wptr_n;
    logic                   rptr, rptr_n;
    logic [CNT_W-1:0]       count, count_n;

    // Formatting of the incoming product
    logic              fmt_ovf;
    logic [DATA_W-1:0] fmt_result;
    logic              fmt_zero;

    logic push, pop;

    // Next-head output values
    logic [DATA_W-1:0] head_result_n;
    logic [TAG_W-1:0]  head_rd_n;
    logic              head_ovf_n;
    logic              head_zero_n;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Format the product at push time; ovf holds for every op
    always_comb begin
        fmt_ovf    = ~((&in_product[127:63]) | ~(|in_product[127:63]));
        fmt_result = in_product[63:0];
        unique case (in_op)
            2'b00: fmt_result = in_product[63:0];
            2'b01: fmt_result = in_product[127:64];
            2'b10: fmt_result = {{32{in_product[31]}}, in_product[31:0]};
            2'b11: begin
                if (!fmt_ovf) begin
                    fmt_result = in_product[63:0];
                end else if (in_product[127]) begin
                    fmt_result = SAT_NEG;
                end else begin
                    fmt_result = SAT_POS;
                end
            end
            default: fmt_result = in_product[63:0];
        endcase
        fmt_zero = (fmt_result == '0);
    end

    // FIFO next state and the head entry that will be visible after the edge
    always_comb begin
        mem_result_n = mem_result;
        mem_rd_n     = mem_rd;
        mem_ovf_n    = mem_ovf;
        mem_zero_n   = mem_zero;
        wptr_n       = wptr;
        rptr_n       = rptr;
        count_n      = count + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            mem_result_n[wptr] = fmt_result;
            mem_rd_n[wptr]     = in_rd;
            mem_ovf_n[wptr]    = fmt_ovf;
            mem_zero_n[wptr]   = fmt_zero;
            wptr_n             = ~wptr;
        end
        if (pop) begin
            rptr_n = ~rptr;
        end

        head_result_n = '0;
        head_rd_n     = '0;
        head_ovf_n    = 1'b0;
        head_zero_n   = 1'b0;
        if (count_n != '0) begin
            head_result_n = mem_result_n[rptr_n];
            head_rd_n     = mem_rd_n[rptr_n];
            head_ovf_n    = mem_ovf_n[rptr_n];
            head_zero_n   = mem_zero_n[rptr_n];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_result <= '0;
            mem_rd     <= '0;
            mem_ovf    <= '0;
            mem_zero   <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            count      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            mem_result <= mem_result_n;
            mem_rd     <= mem_rd_n;
            mem_ovf    <= mem_ovf_n;
            mem_zero   <= mem_zero_n;
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            count      <= count_n;
            in_ready   <= (count_n != CNT_W'(2));
            out_valid  <= (count_n != '0);
            out_result <= head_result_n;
            out_rd     <= head_rd_n;
            out_ovf    <= head_ovf_n;
            out_zero   <= head_zero_n;
        end
    end

endmodule
